pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic ready/valid pipeline stage register with a 2-entry skid buffer, synchronous flush and back-pressure.
//  Next generation of the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB); one instance per stage boundary.
//  Payload is an opaque packed vector (e.g. read data, ALU result, rd, MemtoReg, RegWrite for the MEM/WB boundary).
//  Full throughput (1 transfer/cycle) with registered in_ready, so no combinational ready path crosses the stage.
// PARAMETERS
//  PAYLOAD_W  135  payload width in bits (default = MEM/WB: 64+64+5+1+1)
//  CNT_W      32   stall-counter width; used only when PIPE_STAGE_STALL_CNT_EN is defined
// PORTS
//  clk          in   1          clock; all state updates on the rising edge
//  reset        in   1          synchronous, active-high reset
//  flush        in   1          synchronous kill of every held entry and of the same-cycle input
//  in_valid     in   1          upstream holds a valid payload
//  in_ready     out  1          stage can accept a payload (registered)
//  in_data      in   PAYLOAD_W  upstream payload
//  out_valid    out  1          out_data is valid
//  out_ready    in   1          downstream accepts out_data this cycle
//  out_data     out  PAYLOAD_W  registered payload to the next stage
//  stall_cnt    out  CNT_W      back-pressure cycle count (present only with PIPE_STAGE_STALL_CNT_EN)
// BEHAVIOUR
//  One clock; reset is synchronous and active-high. Ports are named clk and reset.
//  Storage: main entry (drives out_*) and skid entry, each a payload plus a valid bit.
//  Reset (priority 1): both valid bits 0, both payloads 0, out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
//  Flush (priority 2): both valid bits cleared next cycle; same-cycle input discarded; payload contents don't care.
//  Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//  in_ready = ~skid_valid, driven from the register only.
//  Latency: data accepted in cycle N appears on out_data in cycle N+1 when main is empty or drains in cycle N.
//  Normal update, evaluated in order:
//   - Main empty, or main drains this cycle: main <= skid if skid_valid, else main <= input if accepted.
//   - If main <= skid and an input is also accepted: skid <= input, skid stays valid.
//   - Main full and not draining, input accepted: skid <= input, skid_valid=1, so in_ready=0 next cycle.
//   - Skid is written only when main cannot take the input.
//  Order preserved: FIFO, depth 2, no drop or duplication except on flush/reset.
//  Full: skid_valid=1 -> in_ready=0; in_valid is ignored, upstream must hold in_data stable.
//  Empty: out_valid=0; out_ready is ignored.
//  Simultaneous full drain and refill: main<=skid and skid<=input in one cycle only if in_ready was 1, i.e. never from full.
//  Reset or flush mid-stall: entries are lost, in_ready=1 next cycle.
//  out_data holds its last value when out_valid=0 (no bubble zeroing, except at reset).
// CONFIGURATION
//  Macro PIPE_STAGE_STALL_CNT_EN:
//   - Defined: stall_cnt port exists. Increments by 1 each cycle with out_valid & ~out_ready.
//     Saturates at 2^CNT_W-1; cleared only by reset (flush does not clear it).
//   - Undefined: stall_cnt port and counter logic absent; all other behaviour identical.
// STRUCTURE
//  Package pipe_pkg:
//   - XLEN=64, REG_ADDR_W=5.
//   - Packed typedef mem_wb_payload_t {read_data, alu_result, rd, memtoreg, regwrite}; $bits(mem_wb_payload_t)=135.
//   - Per-stage payload typedefs as stages migrate.
//  The block itself stays payload-agnostic (logic vector), so no package import inside the RTL.
//  No sub-module: main/skid control and the optional counter are inline; instantiated once per stage boundary.
// TESTING
//  T1 reset: reset=1 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1; stall_cnt=0.
//  T2 streaming: out_ready=1, in_data=1..8 on consecutive cycles -> out_data=1..8 one cycle later each, in_ready stays 1.
//  T3 back-pressure: send A,B,C with out_ready=0 from A's output cycle:
//   -> A held on out; B in skid; in_ready=0; C held upstream.
//   -> Release out_ready: A, B, C exit in order; stall_cnt equals stalled cycles.
//  T4 flush: main=A, skid=B, in_valid=1 with C, flush=1 -> next cycle out_valid=0, in_ready=1; A, B, C never appear.
//  T5 drain and refill: main=A, skid empty, out_ready=1, in=B -> out=B next cycle, out_valid=1, skid_valid stays 0.
//  T6 saturation (CNT_W=4, macro on): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
//   Repeat T1-T5 with macro off; results identical.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline typedefs. Each stage boundary gets a packed payload typedef as it migrates.
package pipe_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]       read_data;
    logic [XLEN-1:0]       alu_result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  memtoreg;
    logic                  regwrite;
  } mem_wb_payload_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline stage with a 2-entry (main + skid) buffer, synchronous flush and registered in_ready.
// Optional back-pressure counter on port stall_cnt, enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned PAYLOAD_W = 135,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("pipe_stage_skid: CNT_W must be at least 1");
  end

  // out_valid/out_data are the main entry itself
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_data;

  logic                 in_fire;
  logic                 out_fire;
  logic                 main_valid_nxt;
  logic [PAYLOAD_W-1:0] main_data_nxt;
  logic                 skid_valid_nxt;
  logic [PAYLOAD_W-1:0] skid_data_nxt;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    main_valid_nxt = out_valid;
    main_data_nxt  = out_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;

    if (flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (!out_valid || out_fire) begin
      if (skid_valid) begin
        main_valid_nxt = 1'b1;
        main_data_nxt  = skid_data;
        // Unreachable while in_ready mirrors ~skid_valid, kept so the skid never drops an accepted beat
        skid_valid_nxt = in_fire;
        if (in_fire) begin
          skid_data_nxt = in_data;
        end
      end else begin
        main_valid_nxt = in_fire;
        if (in_fire) begin
          main_data_nxt = in_data;
        end
      end
    end else if (in_fire) begin
      skid_valid_nxt = 1'b1;
      skid_data_nxt  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= main_valid_nxt;
      out_data   <= main_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      in_ready   <= ~skid_valid_nxt;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Counts every held-output cycle, flush included; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule : pipe_stage_skid
